// File: rtl/dragon_ram_arbiter.sv
// dragon_ram_arbiter: two-requester arbiter in front of a single-port DragonRAM.
// Each access runs IDLE -> ACCESS -> CAPTURE -> RESP, giving a fixed
// Req(N) -> Gnt(N+1) -> Done(N+3) latency and one access per four cycles.
// Optional feature: define DRAGON_RAM_ARBITER_ROUND_ROBIN_EN to alternate
// ties between requesters; otherwise requester 0 always wins a tie.
module dragon_ram_arbiter #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 36
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Req0,
    input  logic                    Req1,
    input  logic                    Write0,
    input  logic                    Write1,
    input  logic [AddressWidth-1:0] Addr0,
    input  logic [AddressWidth-1:0] Addr1,
    input  logic [DataWidth-1:0]    WData0,
    input  logic [DataWidth-1:0]    WData1,
    output logic                    Gnt0,
    output logic                    Gnt1,
    output logic                    Done0,
    output logic                    Done1,
    output logic [DataWidth-1:0]    RData,
    output logic                    Busy,
    output logic                    RamWriteEnable,
    output logic [AddressWidth-1:0] RamAddress,
    output logic [DataWidth-1:0]    RamWriteData,
    input  logic [DataWidth-1:0]    RamReadData
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic owner;       // requester currently being served (0 or 1)
    logic op_write;    // current access is a write
    logic grant_valid; // at least one request pending
    logic grant_sel;   // requester that wins if a grant is made now

`ifdef DRAGON_RAM_ARBITER_ROUND_ROBIN_EN
    logic last_grant;
`endif

    // Pick the winner among pending requests
    always_comb begin
        grant_valid = Req0 | Req1;
`ifdef DRAGON_RAM_ARBITER_ROUND_ROBIN_EN
        if (Req0 && Req1) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = Req1;
        end
`else
        grant_sel = ~Req0;
`endif
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only IDLE waits, the rest of the sequence is fixed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning command at grant, pulse the write enable for one cycle,
    // and capture registered RAM read data for reads
    always_ff @(posedge Clock) begin
        if (Reset) begin
            RamWriteEnable <= 1'b0;
            RamAddress     <= '0;
            RamWriteData   <= '0;
            RData          <= '0;
            owner          <= 1'b0;
            op_write       <= 1'b0;
`ifdef DRAGON_RAM_ARBITER_ROUND_ROBIN_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            RamWriteEnable <= 1'b0;
            if (state == IDLE && grant_valid) begin
                owner          <= grant_sel;
                op_write       <= grant_sel ? Write1 : Write0;
                RamWriteEnable <= grant_sel ? Write1 : Write0;
                RamAddress     <= grant_sel ? Addr1  : Addr0;
                RamWriteData   <= grant_sel ? WData1 : WData0;
`ifdef DRAGON_RAM_ARBITER_ROUND_ROBIN_EN
                last_grant     <= grant_sel;
`endif
            end
            if (state == CAPTURE && !op_write) begin
                RData <= RamReadData;
            end
        end
    end

    // Handshake outputs decoded from state and owner
    always_comb begin
        Busy  = (state != IDLE);
        Gnt0  = (state == ACCESS) && !owner;
        Gnt1  = (state == ACCESS) &&  owner;
        Done0 = (state == RESP)   && !owner;
        Done1 = (state == RESP)   &&  owner;
    end

endmodule

// File: doc/dragon_ram_arbiter.md
DRAGON_RAM_ARBITER -- requirements
Module: dragon_ram_arbiter

Interface
- Parameters:
  - REQ-001: The block SHALL have parameter AddressWidth, default 10, giving the RAM word address width.
  - REQ-002: The block SHALL have parameter DataWidth, default 36, giving the RAM word width.
- Ports:
  - REQ-003: The block SHALL have port Clock, input, 1 bit: the single clock; all logic is rising-edge.
  - REQ-004: The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
  - REQ-005: The block SHALL have ports Req0/Req1, input, 1 bit: requester N wants a RAM access.
  - REQ-006: The block SHALL have ports Write0/Write1, input, 1 bit: 1 = write, 0 = read; valid while ReqN is high.
  - REQ-007: The block SHALL have ports Addr0/Addr1, input, AddressWidth bits: access address.
  - REQ-008: The block SHALL have ports WData0/WData1, input, DataWidth bits: write data.
  - REQ-009: The block SHALL have ports Gnt0/Gnt1, output, 1 bit: one-cycle pulse; the command has been latched.
  - REQ-010: The block SHALL have ports Done0/Done1, output, 1 bit: one-cycle pulse; the access has completed.
  - REQ-011: The block SHALL have port RData, output, DataWidth bits: read data, valid in the Done cycle of a read.
  - REQ-012: The block SHALL have port Busy, output, 1 bit: high in any state other than IDLE.
  - REQ-013: The block SHALL have port RamWriteEnable, output, 1 bit: write enable to the single DragonRAM port.
  - REQ-014: The block SHALL have port RamAddress, output, AddressWidth bits: RAM port address.
  - REQ-015: The block SHALL have port RamWriteData, output, DataWidth bits: RAM port write data.
  - REQ-016: The block SHALL have port RamReadData, input, DataWidth bits: registered RAM read output, with 1-cycle latency and no update on write cycles.

Function
- REQ-017: The FSM SHALL have exactly four states, IDLE, ACCESS, CAPTURE and RESP, and SHALL advance ACCESS->CAPTURE->RESP->IDLE unconditionally.
- REQ-018: In IDLE with any ReqN high at edge N, the block SHALL latch the winner's Write, Addr and WData into RamWriteEnable/RamAddress/RamWriteData, pulse GntN in cycle N+1 and enter ACCESS.
- REQ-019: RamWriteEnable SHALL be high only in the ACCESS cycle of a write; it SHALL be 0 in every other cycle.
- REQ-020: RamAddress and RamWriteData SHALL hold their latched values from ACCESS until the next grant.
- REQ-021: In CAPTURE (cycle N+2), the block SHALL register RamReadData into RData at the end of the cycle for reads; for writes RData SHALL be unchanged.
- REQ-022: In RESP (cycle N+3), the block SHALL pulse DoneN for the granted requester only; the fixed latency SHALL be Req sampled at N -> Gnt at N+1 -> Done at N+3, for both reads and writes.
- REQ-023: The requester SHALL hold its command stable until it sees Gnt, and MAY drop Req from the cycle after Gnt.
- REQ-024: A Req still high when the block returns to IDLE SHALL be a new request.
- REQ-025: Sustained throughput SHALL be one access per 4 cycles.
- REQ-026: Request inputs SHALL be ignored outside IDLE, with no queuing.
- REQ-027: RData SHALL retain its last value between reads.
- REQ-028: Gnt0/Gnt1 SHALL never be high together, and Done0/Done1 SHALL never be high together.
- REQ-029: The block SHALL perform no address range checking; Addr SHALL be passed through unchanged, truncated to AddressWidth.

Reset
- REQ-030: When Reset is high at an edge, the next cycle SHALL have state=IDLE, Gnt0=Gnt1=Done0=Done1=0, Busy=0, RamWriteEnable=0, RamAddress=0, RamWriteData=0, RData=0 and LastGrant=1.
- REQ-031: For reset mid-operation, a write whose ACCESS cycle coincides with the Reset edge SHALL commit to RAM; no Done SHALL be issued for any aborted transaction, and no Done SHALL appear after reset deasserts.
- REQ-032: A Req high in the first cycle after Reset deasserts SHALL be granted normally.

Configuration
- REQ-033: Macro DRAGON_RAM_ARBITER_ROUND_ROBIN_EN defined: when Req0 and Req1 are both high in IDLE, the block SHALL grant the requester not in LastGrant, and SHALL update LastGrant on every grant.
- REQ-034: Macro not defined: the block SHALL give fixed priority, so requester 0 wins every tie; LastGrant SHALL be absent or unused.
- REQ-035: With only one request pending, both variants SHALL grant that requester immediately.

Verification
- REQ-036: After Reset, a Req1 write of Addr1=0x005 with WData1=0x123456789 at cycle 0 SHALL give Gnt1@1, RamWriteEnable=1 only @1, and Done1@3; a following Req0 read of 0x005 SHALL return RData=0x123456789 with Done0.
- REQ-037: With Req0 and Req1 held high continuously with the macro defined, the grant sequence SHALL be 0,1,0,1 at cycles 1,5,9,13; without the macro it SHALL be 0,0,0,0.
- REQ-038: Reset asserted during CAPTURE of a read SHALL produce no Done, Busy=0 next cycle, and RData=0.
- REQ-039: Reset asserted during ACCESS of a write of 0xABC to 0x3FF SHALL still leave RAM[0x3FF]=0xABC when read afterwards, and SHALL produce no Done for the write.
- REQ-040: Req0 pulsed while Busy, then dropped before IDLE, SHALL never be granted or acknowledged.
- REQ-041: Random traffic checked against a scoreboard SHALL return read data equal to the last completed write, with no simultaneous Gnt or Done and a fixed 3-cycle Req-to-Done latency.
